lfsr_rand_bank: RTL



---
 rtl/lfsr_rand_bank.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lfsr_rand_bank.sv
// Bank of CH Fibonacci LFSRs with a bounded (mask-and-reject) draw port.
// Define LFSR_RAND_STATS_EN to build the saturating rejection counter on rej_cnt.
module lfsr_rand_bank #(
  parameter int             CH      = 6,
  parameter int             W       = 20,
  parameter int             OUT_W   = 8,
  parameter int             STEP    = 2,
  parameter logic [W-1:0]   TAPS    = 20'h90000,
  parameter int             MAX_TRY = 15,
  localparam int            CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  seed_we,
  input  logic [CW-1:0]         seed_ch,
  input  logic [W-1:0]          seed_data,
  output logic [CH*OUT_W-1:0]   rand_flat,
  input  logic                  req,
  input  logic [CW-1:0]         req_ch,
  input  logic [OUT_W-1:0]      req_max,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [OUT_W-1:0]      rsp_data,
  output logic [15:0]           rej_cnt
);

  typedef enum logic [1:0] {IDLE, DRAW, RESP} state_t;

  state_t            state;
  logic [W-1:0]      sreg [CH];
  logic [CW-1:0]     cur_ch;
  logic [OUT_W-1:0]  cur_max;
  logic [OUT_W-1:0]  cur_mask;
  logic [7:0]        try_cnt;
  logic [OUT_W-1:0]  draw_v;

  function automatic logic [W-1:0] lfsr_adv(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = s;
    for (int k = 0; k < STEP; k++) r = {r[W-2:0], ^(r & TAPS)};
    return r;
  endfunction

  // Smallest all-ones mask covering m: smear every set bit downward.
  function automatic logic [OUT_W-1:0] mask_of(input logic [OUT_W-1:0] m);
    logic [OUT_W-1:0] r;
    r = m;
    for (int k = 1; k < OUT_W; k++) r = r | (m >> k);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (rst)
        sreg[i] <= {W{1'b1}} ^ W'(i << 1);
      else if (seed_we && seed_ch == CW'(i))
        sreg[i] <= (seed_data == '0) ? {W{1'b1}} : seed_data;
      else if (en)
        sreg[i] <= lfsr_adv(sreg[i]);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_flat
    assign rand_flat[g*OUT_W +: OUT_W] = sreg[g][OUT_W-1:0];
  end

  assign draw_v = sreg[cur_ch][OUT_W-1:0] & cur_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cur_ch    <= '0;
      cur_max   <= '0;
      cur_mask  <= '0;
      try_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !busy) begin
            cur_ch   <= (int'(req_ch) < CH) ? req_ch : '0;
            cur_max  <= req_max;
            cur_mask <= mask_of(req_max);
            try_cnt  <= '0;
            state    <= DRAW;
            busy     <= 1'b1;
          end
        end
        DRAW: begin
          if (draw_v <= cur_max) begin
            rsp_data  <= draw_v;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (try_cnt == 8'(MAX_TRY - 1)) begin
            rsp_data  <= cur_max;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            try_cnt <= try_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LFSR_RAND_STATS_EN
  logic        rejecting;
  logic [15:0] rej_q;

  assign rejecting = (state == DRAW) && (draw_v > cur_max);

  always_ff @(posedge clk) begin
    if (rst)
      rej_q <= '0;
    else if (rejecting && rej_q != 16'hFFFF)
      rej_q <= rej_q + 16'd1;
  end

  assign rej_cnt = rej_q;
`else
  assign rej_cnt = '0;
`endif

endmodule
